// File: rtl/rx_align_if.sv
// Handshake and data bundle between the PSL read-data buffer side and rx_align.
// The master modport is the beat source and line sink; the slave modport is the realigner.
interface rx_align_if;
  logic         in_ready_o;
  logic         in_val_i;
  logic [511:0] in_dat_i;
  logic [2:0]   in_qw_start_i;
  logic [3:0]   in_qw_cnt_i;
  logic         in_last_i;
  logic         out_val_o;
  logic         out_ready_i;
  logic [511:0] out_dat_o;
  logic [6:0]   out_byte_o;
  logic         out_eop_o;
  logic         err_o;

  modport master (
    input  in_ready_o, out_val_o, out_dat_o, out_byte_o, out_eop_o, err_o,
    output in_val_i, in_dat_i, in_qw_start_i, in_qw_cnt_i, in_last_i, out_ready_i
  );

  modport slave (
    input  in_val_i, in_dat_i, in_qw_start_i, in_qw_cnt_i, in_last_i, out_ready_i,
    output in_ready_o, out_val_o, out_dat_o, out_byte_o, out_eop_o, err_o
  );
endinterface

// File: rtl/rx_align.sv
// Receive-side realigner: packs contiguous qword runs from half-line read beats
// densely into 512-bit lines with a byte count and end-of-packet.
module rx_align #(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  rx_align_if.slave  bus
);

  typedef enum logic [0:0] {
    ACC   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        fill_q, fill_d;
  logic [7:0][63:0]  hold_q, hold_d;
  logic              out_val_q, out_val_d;
  logic [511:0]      out_dat_q, out_dat_d;
  logic [6:0]        out_byte_q, out_byte_d;
  logic              out_eop_q, out_eop_d;
  logic              err_q, err_d;

  logic [7:0][63:0]  in_lanes_s;
  logic [7:0][63:0]  rot_s;
  logic [7:0][63:0]  merged_s;
  logic [2:0]        rot_amt_s;
  logic [4:0]        total_s;
  logic              out_free_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              proto_bad_s;

  // Move lane k to lane (k + r) mod 8, so the run's first qword lands on the fill point.
  function automatic logic [7:0][63:0] rotate_up(input logic [7:0][63:0] d, input logic [2:0] r);
    logic [7:0][63:0] o;
    logic [2:0]       src;
    o = '0;
    for (int j = 0; j < 8; j++) begin
      src  = 3'(j) - r;
      o[j] = d[src];
    end
    return o;
  endfunction

  function automatic logic [7:0][63:0] mask_lanes(input logic [7:0][63:0] d, input logic [3:0] n);
    logic [7:0][63:0] o;
    o = '0;
    for (int j = 0; j < 8; j++) begin
      o[j] = (4'(j) < n) ? d[j] : 64'd0;
    end
    return o;
  endfunction

  assign in_lanes_s = bus.in_dat_i;
  assign rot_amt_s  = fill_q - bus.in_qw_start_i;
  assign rot_s      = rotate_up(in_lanes_s, rot_amt_s);
  assign total_s    = {2'b00, fill_q} + {1'b0, bus.in_qw_cnt_i};
  assign out_free_s = ~out_val_q | bus.out_ready_i;
  assign in_ready_s = (state_q == ACC) & out_free_s;
  assign accept_s   = bus.in_val_i & in_ready_s;

  assign proto_bad_s = (bus.in_qw_cnt_i == 4'd0) |
                       (bus.in_qw_cnt_i > 4'd8) |
                       (({2'b00, bus.in_qw_start_i} + {1'b0, bus.in_qw_cnt_i}) > 5'd8) |
                       (state_q == FLUSH);

  // Lanes below the fill point keep held qwords; the rest come from the rotated beat.
  always_comb begin
    merged_s = '0;
    for (int j = 0; j < 8; j++) begin
      merged_s[j] = (3'(j) < fill_q) ? hold_q[j] : rot_s[j];
    end
  end

  // Next-state, hold, fill and output-register logic.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    hold_d     = hold_q;
    out_val_d  = out_val_q & ~bus.out_ready_i;
    out_dat_d  = out_dat_q;
    out_byte_d = out_byte_q;
    out_eop_d  = out_eop_q;
    err_d      = err_q | (CHECK_EN & bus.in_val_i & proto_bad_s);

    case (state_q)
      ACC: begin
        if (accept_s) begin
          if (total_s < 5'd8) begin
            if (bus.in_last_i) begin
              out_val_d  = 1'b1;
              out_dat_d  = mask_lanes(merged_s, total_s[3:0]);
              out_byte_d = {1'b0, total_s[2:0], 3'b000};
              out_eop_d  = 1'b1;
              fill_d     = 3'd0;
            end else begin
              hold_d = merged_s;
              fill_d = total_s[2:0];
            end
          end else begin
            // Overflow qwords wrapped into the low rotated lanes become the new hold.
            out_val_d  = 1'b1;
            out_dat_d  = merged_s;
            out_byte_d = 7'd64;
            out_eop_d  = bus.in_last_i & (total_s == 5'd8);
            hold_d     = rot_s;
            fill_d     = total_s[2:0];
            state_d    = (bus.in_last_i & (total_s > 5'd8)) ? FLUSH : ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      FLUSH: begin
        if (out_free_s) begin
          out_val_d  = 1'b1;
          out_dat_d  = mask_lanes(hold_q, {1'b0, fill_q});
          out_byte_d = {1'b0, fill_q, 3'b000};
          out_eop_d  = 1'b1;
          fill_d     = 3'd0;
          state_d    = ACC;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACC;
      fill_q     <= 3'd0;
      hold_q     <= '0;
      out_val_q  <= 1'b0;
      out_dat_q  <= 512'd0;
      out_byte_q <= 7'd0;
      out_eop_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      hold_q     <= hold_d;
      out_val_q  <= out_val_d;
      out_dat_q  <= out_dat_d;
      out_byte_q <= out_byte_d;
      out_eop_q  <= out_eop_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready_o = in_ready_s;
  assign bus.out_val_o  = out_val_q;
  assign bus.out_dat_o  = out_dat_q;
  assign bus.out_byte_o = out_byte_q;
  assign bus.out_eop_o  = out_eop_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_rx_align.sv
// Randomised scoreboard bench for rx_align: a qword-queue packing model predicts
// every output line; a separate monitor pops and compares on each handshake.
module tb_rx_align;

  logic clk;
  logic reset;

  rx_align_if bus ();

  rx_align #(.CHECK_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [511:0] dat;
    logic [6:0]   nb;
    logic         eop;
  } line_t;

  line_t       exp_q[$];
  logic [63:0] pend[$];
  int          errors = 0;
  int          checks = 0;
  int          rdy_mode = 0;
  bit          mon_en = 1'b1;
  bit          stall_v = 1'b0;
  logic [511:0] stall_dat;
  logic [6:0]  stall_nb;
  logic        stall_eop;
  line_t       mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference: qwords queue up in arrival order; every 8 make a full line, last flushes the rest.
  task automatic model_beat(input int st, input int cn, input bit lst, input logic [511:0] d);
    line_t l;
    int    n;
    for (int k = 0; k < cn; k++) pend.push_back(d[(st + k)*64 +: 64]);
    while (pend.size() >= 8) begin
      l.dat = '0;
      for (int k = 0; k < 8; k++) l.dat[k*64 +: 64] = pend.pop_front();
      l.nb  = 7'd64;
      l.eop = lst && (pend.size() == 0);
      exp_q.push_back(l);
    end
    if (lst && pend.size() > 0) begin
      n     = pend.size();
      l.dat = '0;
      for (int k = 0; k < n; k++) l.dat[k*64 +: 64] = pend.pop_front();
      l.nb  = 7'(n * 8);
      l.eop = 1'b1;
      exp_q.push_back(l);
    end
  endtask

  // Sink readiness pattern, updated each falling edge.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.out_ready_i = 1'b1;
      1:       bus.out_ready_i = ($urandom_range(0, 3) != 0);
      default: bus.out_ready_i = 1'b0;
    endcase
  end

  // Monitor: compares each handshaken line against the scoreboard, checks stall stability.
  always begin
    @(negedge clk);
    #2;
    if (!reset && mon_en) begin
      if (stall_v) begin
        chk("stall_dat", bus.out_dat_o, stall_dat);
        chk("stall_byte", 512'(bus.out_byte_o), 512'(stall_nb));
        chk("stall_eop", 512'(bus.out_eop_o), 512'(stall_eop));
      end
      if (bus.out_val_o && !bus.out_ready_i) begin
        chk("stall_in_ready", 512'(bus.in_ready_o), 512'd0);
        stall_v   = 1'b1;
        stall_dat = bus.out_dat_o;
        stall_nb  = bus.out_byte_o;
        stall_eop = bus.out_eop_o;
      end else begin
        stall_v = 1'b0;
      end
      if (bus.out_val_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_line: got byte=%0d eop=%0b expected no line", bus.out_byte_o, bus.out_eop_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("line_dat", bus.out_dat_o, mon_e.dat);
          chk("line_byte", 512'(bus.out_byte_o), 512'(mon_e.nb));
          chk("line_eop", 512'(bus.out_eop_o), 512'(mon_e.eop));
        end
      end
    end else begin
      stall_v = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    bus.in_val_i = 1'b0;
    exp_q.delete();
    pend.delete();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Presents one beat only in a cycle where the block is ready, so it is accepted at the next edge.
  task automatic send_beat(input int st, input int cn, input bit lst, input logic [511:0] d, input bit model);
    int budget;
    budget = 0;
    @(negedge clk);
    #1;
    bus.in_val_i = 1'b0;
    while (!bus.in_ready_o && budget < 1000) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!bus.in_ready_o) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 1000 cycles");
    end else begin
      bus.in_val_i      = 1'b1;
      bus.in_dat_i      = d;
      bus.in_qw_start_i = 3'(st);
      bus.in_qw_cnt_i   = 4'(cn);
      bus.in_last_i     = lst;
      if (model) model_beat(st, cn, lst, d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      bus.in_val_i = 1'b0;
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    rdy_mode = 0;
    idle(1);
    while ((exp_q.size() != 0 || bus.out_val_o) && b < 2000) begin
      @(negedge clk);
      b++;
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", 512'(exp_q.size()), 512'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_val"}, 512'(bus.out_val_o), 512'd0);
    chk({tag, "_out_dat"}, bus.out_dat_o, 512'd0);
    chk({tag, "_out_byte"}, 512'(bus.out_byte_o), 512'd0);
    chk({tag, "_out_eop"}, 512'(bus.out_eop_o), 512'd0);
    chk({tag, "_err"}, 512'(bus.err_o), 512'd0);
    chk({tag, "_in_ready"}, 512'(bus.in_ready_o), 512'd1);
  endtask

  initial begin
    int st, cn;
    bit lst;
    reset             = 1'b1;
    bus.in_val_i      = 1'b0;
    bus.in_dat_i      = '0;
    bus.in_qw_start_i = 3'd0;
    bus.in_qw_cnt_i   = 4'd0;
    bus.in_last_i     = 1'b0;
    bus.out_ready_i   = 1'b1;
    do_reset();
    check_reset_state("reset");

    // Aligned passthrough stream
    for (int i = 0; i < 4; i++) send_beat(0, 8, i == 3, rand512(), 1'b1);
    drain();

    // Unaligned pack followed by a flush cycle
    send_beat(5, 3, 1'b0, rand512(), 1'b1);
    send_beat(0, 8, 1'b1, rand512(), 1'b1);
    @(negedge clk);
    #1;
    bus.in_val_i = 1'b0;
    chk("flush_in_ready_low", 512'(bus.in_ready_o), 512'd0);
    @(negedge clk);
    #1;
    chk("after_flush_in_ready", 512'(bus.in_ready_o), 512'd1);
    drain();

    // Exact fill with last: fill 6 then 2 more
    send_beat(2, 6, 1'b0, rand512(), 1'b1);
    send_beat(2, 2, 1'b1, rand512(), 1'b1);
    drain();

    // Short job
    send_beat(7, 1, 1'b1, rand512(), 1'b1);
    drain();

    // Backpressure in the middle of an aligned stream
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(0, 8, i == 7, rand512(), 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        #3;
        rdy_mode = 2;
        repeat (5) @(negedge clk);
        #3;
        rdy_mode = 0;
      end
    join
    drain();

    // Randomised jobs with random sink readiness
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      st  = $urandom_range(0, 7);
      cn  = $urandom_range(1, 8 - st);
      lst = ($urandom_range(0, 5) == 0) || (i == 399);
      send_beat(st, cn, lst, rand512(), 1'b1);
    end
    drain();

    // Protocol error is sticky until reset
    mon_en = 1'b0;
    send_beat(6, 4, 1'b0, rand512(), 1'b0);
    @(negedge clk);
    #1;
    bus.in_val_i = 1'b0;
    chk("err_set", 512'(bus.err_o), 512'd1);
    idle(4);
    chk("err_sticky", 512'(bus.err_o), 512'd1);
    do_reset();
    mon_en = 1'b1;
    check_reset_state("err_reset");

    // Reset mid-job discards held qwords; next job packs from lane 0
    send_beat(0, 3, 1'b0, rand512(), 1'b1);
    send_beat(1, 2, 1'b0, rand512(), 1'b1);
    do_reset();
    check_reset_state("midjob_reset");
    send_beat(7, 1, 1'b1, rand512(), 1'b1);
    send_beat(3, 5, 1'b0, rand512(), 1'b1);
    send_beat(0, 8, 1'b1, rand512(), 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
